// File: rtl/nn_inference_sequencer.sv
// Sequences one fully-connected layer over a binarised image: walks every
// (neuron, pixel) pair, accumulates weights of set pixels, tracks the argmax.
module nn_inference_sequencer #(
    parameter int NUM_PIX   = 196,
    parameter int NUM_OUT   = 10,
    parameter int PIX_IDX_W = 8,
    parameter int OUT_IDX_W = 4,
    parameter int W_W       = 8,
    parameter int ACC_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 image_ready,
    output logic [PIX_IDX_W-1:0] pixel_idx,
    output logic [OUT_IDX_W-1:0] neuron_idx,
    input  logic                 pixel_in,
    input  logic [W_W-1:0]       weight_in,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_IDX_W-1:0] class_bcd,
    output logic [ACC_W-1:0]     class_score
);

    localparam logic [PIX_IDX_W-1:0] LAST_PIX = PIX_IDX_W'(NUM_PIX - 1);
    localparam logic [OUT_IDX_W-1:0] LAST_OUT = OUT_IDX_W'(NUM_OUT - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic                    issue_v;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] best_score;
    logic [OUT_IDX_W-1:0]    best_idx;
    logic                    new_best;

    // One extra bit of headroom, then clamp back into the ACC_W range.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [W_W-1:0]   w
    );
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W+1-W_W){w[W_W-1]}}, w};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_W-1:0];
    endfunction

    assign new_best = acc > best_score;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        case (state)
            S_IDLE: begin
                if (image_ready) state_n = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (!image_ready)               state_n = S_IDLE;
                else if (pixel_idx == LAST_PIX) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_n = image_ready ? S_COMPARE : S_IDLE;
            end
            S_COMPARE: begin
                busy = 1'b1;
                if (!image_ready)                state_n = S_IDLE;
                else if (neuron_idx == LAST_OUT) state_n = S_DONE;
                else                             state_n = S_MAC;
            end
            S_DONE: begin
                if (!image_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Data for an address issued in MAC arrives one cycle later, flagged by issue_v.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_idx   <= '0;
            neuron_idx  <= '0;
            issue_v     <= 1'b0;
            acc         <= '0;
            best_score  <= ACC_MIN;
            best_idx    <= '0;
            done        <= 1'b0;
            class_bcd   <= '0;
            class_score <= '0;
        end else begin
            issue_v <= (state == S_MAC) && image_ready;
            if (issue_v && pixel_in) acc <= sat_add(acc, weight_in);
            case (state)
                S_IDLE: begin
                    if (image_ready) begin
                        pixel_idx  <= '0;
                        neuron_idx <= '0;
                        acc        <= '0;
                        best_score <= ACC_MIN;
                        best_idx   <= '0;
                    end
                end
                S_MAC: begin
                    if (image_ready && pixel_idx != LAST_PIX) pixel_idx <= pixel_idx + 1'b1;
                end
                S_COMPARE: begin
                    if (image_ready) begin
                        if (new_best) begin
                            best_score <= acc;
                            best_idx   <= neuron_idx;
                        end
                        if (neuron_idx == LAST_OUT) begin
                            class_bcd   <= new_best ? neuron_idx : best_idx;
                            class_score <= new_best ? acc : best_score;
                            done        <= 1'b1;
                        end else begin
                            neuron_idx <= neuron_idx + 1'b1;
                            pixel_idx  <= '0;
                            acc        <= '0;
                        end
                    end
                end
                S_DONE: begin
                    if (!image_ready) done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: default, small and narrow-accumulator
// instances fed from shared image/weight memories, checked against an argmax model.
module tb_nn_inference_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic rdy_m, rdy_s, rdy_t;
    logic [7:0] pidx_m, pidx_s, pidx_t;
    logic [3:0] nidx_m, nidx_s, nidx_t;
    logic pix_m, pix_s, pix_t;
    logic [7:0] wt_m, wt_s, wt_t;
    logic busy_m, busy_s, busy_t;
    logic done_m, done_s, done_t;
    logic [3:0] cls_m, cls_s, cls_t;
    logic [15:0] sc_m, sc_s;
    logic [7:0] sc_t;

    bit img[256];
    logic signed [7:0] w[16][256];

    int total = 0;
    int bad = 0;

    nn_inference_sequencer dut_m (
        .clk(clk), .reset(reset), .image_ready(rdy_m), .pixel_idx(pidx_m),
        .neuron_idx(nidx_m), .pixel_in(pix_m), .weight_in(wt_m), .busy(busy_m),
        .done(done_m), .class_bcd(cls_m), .class_score(sc_m)
    );

    nn_inference_sequencer #(.NUM_PIX(4), .NUM_OUT(3)) dut_s (
        .clk(clk), .reset(reset), .image_ready(rdy_s), .pixel_idx(pidx_s),
        .neuron_idx(nidx_s), .pixel_in(pix_s), .weight_in(wt_s), .busy(busy_s),
        .done(done_s), .class_bcd(cls_s), .class_score(sc_s)
    );

    nn_inference_sequencer #(.NUM_PIX(4), .NUM_OUT(1), .ACC_W(8)) dut_t (
        .clk(clk), .reset(reset), .image_ready(rdy_t), .pixel_idx(pidx_t),
        .neuron_idx(nidx_t), .pixel_in(pix_t), .weight_in(wt_t), .busy(busy_t),
        .done(done_t), .class_bcd(cls_t), .class_score(sc_t)
    );

    // Image array and weight ROM, one-cycle read latency
    always @(posedge clk) begin
        pix_m <= img[pidx_m];
        wt_m  <= w[nidx_m][pidx_m];
        pix_s <= img[pidx_s];
        wt_s  <= w[nidx_s][pidx_s];
        pix_t <= img[pidx_t];
        wt_t  <= w[nidx_t][pidx_t];
    end

    // Score per neuron = clamped running sum of weights at set pixels; first maximum wins.
    function automatic void model(input int np, input int no, input int accw,
                                  output int cls, output int score);
        int hi, lo, s, best;
        hi = (1 << (accw - 1)) - 1;
        lo = -(1 << (accw - 1));
        cls = 0;
        best = 0;
        for (int n = 0; n < no; n++) begin
            s = 0;
            for (int p = 0; p < np; p++) begin
                if (img[p]) begin
                    s += int'(w[n][p]);
                    if (s > hi) s = hi;
                    if (s < lo) s = lo;
                end
            end
            if (n == 0 || s > best) begin
                best = s;
                cls = n;
            end
        end
        score = best;
    endfunction

    function automatic logic dn(input int which);
        case (which)
            0: return done_m;
            1: return done_s;
            default: return done_t;
        endcase
    endfunction

    function automatic logic bz(input int which);
        case (which)
            0: return busy_m;
            1: return busy_s;
            default: return busy_t;
        endcase
    endfunction

    task automatic wait_done(input int which, input int limit, output int cnt, output bit ovl);
        cnt = 0;
        ovl = 1'b0;
        while (dn(which) !== 1'b1 && cnt < limit) begin
            @(posedge clk); #1;
            cnt++;
            if (dn(which) === 1'b1 && bz(which) === 1'b1) ovl = 1'b1;
        end
    endtask

    task automatic randomize_memory(input int np, input int no);
        for (int p = 0; p < np; p++) img[p] = bit'($urandom_range(0, 1));
        for (int n = 0; n < no; n++)
            for (int p = 0; p < np; p++) w[n][p] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rdy_m = 1'b0; rdy_s = 1'b0; rdy_t = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 6;
        if (busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_m); end
        if (done_m !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done_m); end
        if (cls_m !== 4'd0) begin bad++; $display("FAIL reset_class got=%0d want=0", cls_m); end
        if (sc_m !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", sc_m); end
        if (pidx_m !== 8'd0) begin bad++; $display("FAIL reset_pixel_idx got=%0d want=0", pidx_m); end
        if (nidx_m !== 4'd0) begin bad++; $display("FAIL reset_neuron_idx got=%0d want=0", nidx_m); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_full;
        int cnt, ecls, esc;
        bit ovl;
        randomize_memory(196, 10);
        model(196, 10, 16, ecls, esc);
        rdy_m = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 2500, cnt, ovl);
        total += 4;
        if (cnt !== 1980) begin bad++; $display("FAIL full_latency got=%0d want=1980", cnt); end
        if (cls_m !== 4'(ecls)) begin bad++; $display("FAIL full_class got=%0d want=%0d", cls_m, ecls); end
        if (sc_m !== 16'(esc)) begin bad++; $display("FAIL full_score got=%0d want=%0d", $signed(sc_m), esc); end
        if (ovl) begin bad++; $display("FAIL full_busy_done_overlap got=1 want=0"); end
        rdy_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        rdy_m = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (busy_m !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy_m); end
        if (done_m !== 1'b0) begin bad++; $display("FAIL midreset_done got=%0b want=0", done_m); end
        if (cls_m !== 4'd0) begin bad++; $display("FAIL midreset_class got=%0d want=0", cls_m); end
        if (pidx_m !== 8'd0) begin bad++; $display("FAIL midreset_pixel_idx got=%0d want=0", pidx_m); end
        reset = 1'b0;
        rdy_m = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy_m !== 1'b0) begin bad++; $display("FAIL midreset_idle got busy=%0b want=0", busy_m); end
    endtask

    task automatic test_small_ramp;
        int cnt;
        bit ovl, held;
        for (int p = 0; p < 4; p++) img[p] = 1'b1;
        for (int n = 0; n < 3; n++)
            for (int p = 0; p < 4; p++) w[n][p] = 8'(n + 1);
        rdy_s = 1'b1;
        @(posedge clk); #1;
        wait_done(1, 100, cnt, ovl);
        total += 4;
        if (cnt !== 18) begin bad++; $display("FAIL ramp_latency got=%0d want=18", cnt); end
        if (cls_s !== 4'd2) begin bad++; $display("FAIL ramp_class got=%0d want=2", cls_s); end
        if (sc_s !== 16'd12) begin bad++; $display("FAIL ramp_score got=%0d want=12", $signed(sc_s)); end
        if (ovl) begin bad++; $display("FAIL ramp_busy_done_overlap got=1 want=0"); end
        held = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_s !== 1'b1 || busy_s !== 1'b0) held = 1'b0;
        end
        total++;
        if (!held) begin bad++; $display("FAIL ramp_hold got=rerun_or_drop want=done_held"); end
        rdy_s = 1'b0;
        @(posedge clk); #1;
        total += 2;
        if (done_s !== 1'b0) begin bad++; $display("FAIL ramp_done_fall got=%0b want=0", done_s); end
        if (cls_s !== 4'd2) begin bad++; $display("FAIL ramp_class_kept got=%0d want=2", cls_s); end
    endtask

    task automatic test_small_tie;
        int cnt;
        bit ovl;
        img[0] = 1'b1; img[1] = 1'b0; img[2] = 1'b1; img[3] = 1'b1;
        for (int p = 0; p < 4; p++) begin
            w[0][p] = -8'sd1;
            w[1][p] = 8'sd5;
            w[2][p] = 8'sd5;
        end
        rdy_s = 1'b1;
        @(posedge clk); #1;
        wait_done(1, 100, cnt, ovl);
        total += 2;
        if (cls_s !== 4'd1) begin bad++; $display("FAIL tie_class got=%0d want=1", cls_s); end
        if (sc_s !== 16'd15) begin bad++; $display("FAIL tie_score got=%0d want=15", $signed(sc_s)); end
        rdy_s = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_small_random;
        int cnt, ecls, esc;
        bit ovl;
        for (int it = 0; it < 12; it++) begin
            randomize_memory(4, 3);
            if (it % 3 == 0)
                for (int p = 0; p < 4; p++) w[2][p] = w[1][p];
            model(4, 3, 16, ecls, esc);
            rdy_s = 1'b1;
            @(posedge clk); #1;
            wait_done(1, 100, cnt, ovl);
            total += 3;
            if (cnt !== 18) begin bad++; $display("FAIL rand_small_latency it=%0d got=%0d want=18", it, cnt); end
            if (cls_s !== 4'(ecls)) begin bad++; $display("FAIL rand_small_class it=%0d got=%0d want=%0d", it, cls_s, ecls); end
            if (sc_s !== 16'(esc)) begin bad++; $display("FAIL rand_small_score it=%0d got=%0d want=%0d", it, $signed(sc_s), esc); end
            rdy_s = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation;
        int cnt, ecls, esc;
        bit ovl;
        for (int it = 0; it < 8; it++) begin
            if (it == 0 || it == 1) begin
                for (int p = 0; p < 4; p++) begin
                    img[p] = 1'b1;
                    w[0][p] = (it == 0) ? 8'sd127 : -8'sd128;
                end
            end else begin
                randomize_memory(4, 1);
            end
            model(4, 1, 8, ecls, esc);
            rdy_t = 1'b1;
            @(posedge clk); #1;
            wait_done(2, 50, cnt, ovl);
            total += 3;
            if (cnt !== 6) begin bad++; $display("FAIL sat_latency it=%0d got=%0d want=6", it, cnt); end
            if (cls_t !== 4'd0) begin bad++; $display("FAIL sat_class it=%0d got=%0d want=0", it, cls_t); end
            if (sc_t !== 8'(esc)) begin bad++; $display("FAIL sat_score it=%0d got=%0d want=%0d", it, $signed(sc_t), esc); end
            rdy_t = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_image;
        int cnt;
        bit ovl;
        randomize_memory(196, 10);
        for (int p = 0; p < 196; p++) img[p] = 1'b0;
        rdy_m = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 2500, cnt, ovl);
        total += 3;
        if (cnt !== 1980) begin bad++; $display("FAIL zero_latency got=%0d want=1980", cnt); end
        if (cls_m !== 4'd0) begin bad++; $display("FAIL zero_class got=%0d want=0", cls_m); end
        if (sc_m !== 16'd0) begin bad++; $display("FAIL zero_score got=%0d want=0", $signed(sc_m)); end
        rdy_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort_restart;
        int cnt, ecls, esc, guard;
        bit ovl, quiet, held;
        logic [3:0] prev_cls;
        logic [15:0] prev_sc;
        prev_cls = cls_m;
        prev_sc = sc_m;
        randomize_memory(196, 10);
        model(196, 10, 16, ecls, esc);
        rdy_m = 1'b1;
        guard = 0;
        while (!(nidx_m === 4'd3 && pidx_m === 8'd50) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (guard >= 3000) begin bad++; $display("FAIL abort_reach got=timeout want=neuron3_pixel50"); end
        rdy_m = 1'b0;
        @(posedge clk); #1;
        total += 3;
        if (busy_m !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy_m); end
        if (cls_m !== prev_cls) begin bad++; $display("FAIL abort_class got=%0d want=%0d", cls_m, prev_cls); end
        if (sc_m !== prev_sc) begin bad++; $display("FAIL abort_score got=%0d want=%0d", sc_m, prev_sc); end
        quiet = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_m !== 1'b0 || busy_m !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL abort_quiet got=activity want=idle"); end
        rdy_m = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 2500, cnt, ovl);
        total += 4;
        if (cnt !== 1980) begin bad++; $display("FAIL restart_latency got=%0d want=1980", cnt); end
        if (cls_m !== 4'(ecls)) begin bad++; $display("FAIL restart_class got=%0d want=%0d", cls_m, ecls); end
        if (sc_m !== 16'(esc)) begin bad++; $display("FAIL restart_score got=%0d want=%0d", $signed(sc_m), esc); end
        if (ovl) begin bad++; $display("FAIL restart_busy_done_overlap got=1 want=0"); end
        held = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_m !== 1'b1 || busy_m !== 1'b0) held = 1'b0;
        end
        total++;
        if (!held) begin bad++; $display("FAIL hold_no_rerun got=rerun_or_drop want=done_held"); end
        rdy_m = 1'b0;
        @(posedge clk); #1;
        total += 2;
        if (done_m !== 1'b0) begin bad++; $display("FAIL hold_done_fall got=%0b want=0", done_m); end
        if (cls_m !== 4'(ecls)) begin bad++; $display("FAIL hold_class_kept got=%0d want=%0d", cls_m, ecls); end
    endtask

    initial begin
        test_reset();
        test_random_full();
        test_reset_mid();
        test_small_ramp();
        test_small_tie();
        test_small_random();
        test_saturation();
        test_zero_image();
        test_abort_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_inference_sequencer.md
Name: nn_inference_sequencer

Overview:
Controller that sequences one fully-connected layer over the binarised 14x14 image held by the image reader.
- Walks every (output neuron, pixel) pair and drives the pixel index and weight ROM addresses.
- Accumulates signed weights for set pixels and tracks the running argmax.
- Presents the winning class as BCD with a level completion flag for the 7-seg/BCD output stage and the host handshake.

Parameters:
- NUM_PIX, 196, pixels per image (image_array bits).
- NUM_OUT, 10, output neurons / classes.
- PIX_IDX_W, 8, width of pixel_idx (must hold NUM_PIX-1).
- OUT_IDX_W, 4, width of neuron_idx and class_bcd.
- W_W, 8, signed weight width.
- ACC_W, 16, signed accumulator width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- image_ready  in  1  level from image reader: full image present in image_array.
- pixel_idx  out  PIX_IDX_W  index into image_array for the current MAC address.
- neuron_idx  out  OUT_IDX_W  current output neuron (upper weight-ROM address field).
- pixel_in  in  1  image_array[pixel_idx], valid the cycle after the address is issued.
- weight_in  in  W_W  signed weight W[neuron_idx][pixel_idx], ROM latency 1 cycle.
- busy  out  1  high in MAC, DRAIN and COMPARE states.
- done  out  1  classification complete (level).
- class_bcd  out  OUT_IDX_W  winning class, valid while done=1.
- class_score  out  ACC_W  winning accumulator value, valid while done=1.

Behaviour:
- Reset: state=IDLE; pixel_idx=0, neuron_idx=0, busy=0, done=0, class_bcd=0, class_score=0, acc=0, issue_v=0. Reset overrides everything, including mid-inference.
- Address/data alignment:
  - issue_v registers 1 for each cycle an address is issued in MAC.
  - When issue_v=1, the datapath samples pixel_in/weight_in: acc <= sat(acc + sext(weight_in)) if pixel_in=1, else acc unchanged.
- Saturation: the sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- IDLE:
  - If image_ready=1 -> MAC with neuron_idx=0, pixel_idx=0, acc=0, best_score=most-negative ACC_W value, best_idx=0.
  - Otherwise stay in IDLE.
- MAC:
  - Each cycle, issue the address: issue_v<=1.
  - If pixel_idx==NUM_PIX-1 -> DRAIN, else pixel_idx++.
- DRAIN:
  - issue_v<=0; the last product accumulates this cycle. -> COMPARE.
- COMPARE:
  - If acc > best_score (signed, strict) then best_score<=acc, best_idx<=neuron_idx. Ties keep the lower index.
  - If neuron_idx==NUM_OUT-1 -> DONE: class_bcd<=best_idx, or neuron_idx when this neuron wins; class_score is set the same way; done<=1.
  - Otherwise neuron_idx++, pixel_idx<=0, acc<=0 -> MAC.
- DONE:
  - done, class_bcd and class_score hold.
  - When image_ready=0: done<=0 -> IDLE, with class_bcd/class_score retained.
  - Exactly one inference runs per image_ready high period.
- Abort: image_ready=0 in MAC/DRAIN/COMPARE -> IDLE next edge. busy=0, issue_v=0, done stays 0, class outputs unchanged.
- Latency:
  - Per neuron: NUM_PIX+2 cycles.
  - done rises NUM_OUT*(NUM_PIX+2) edges after the edge at which IDLE samples image_ready=1 (1980 for defaults).
- busy and done are never both 1.
- pixel_idx and neuron_idx never exceed NUM_PIX-1 and NUM_OUT-1.

Test Plan:
- Reset: hold reset 3 cycles during MAC -> next cycle state IDLE, busy=0, done=0, class_bcd=0, pixel_idx=0.
- Small config NUM_PIX=4, NUM_OUT=3, all pixels 1, weights W[n][p]=n+1 -> accs 4, 8, 12. done rises exactly 18 edges after start; class_bcd=2, class_score=12.
- Tie and negatives (NUM_PIX=4, NUM_OUT=3): W[0]=all -1, W[1]=W[2]=all +5, pixels 1011 -> scores -3, 15, 15. class_bcd=1 (lower index wins).
- Zero image, defaults: all pixels 0, any weights -> all scores 0; class_bcd=0, class_score=0, done after 1980 cycles.
- Saturation with ACC_W=8: NUM_PIX=4, all weights +127, pixels 1 -> score 127, not wrapped. All weights -128 -> score -128.
- Handshake and abort:
  - Drop image_ready at pixel_idx=50 of neuron 3 -> IDLE next cycle, done never asserts.
  - Reassert image_ready -> full 1980-cycle run restarts from neuron 0.
  - Keep image_ready high after done -> no second run; drop it -> done falls next edge.
